// File: rtl/pyr_pkg.sv
// Shared definitions for the 2x2 averaging pyramid frame sequencer.
package pyr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE,
    ST_DRAIN
  } pyr_state_e;

  localparam int unsigned PYR_ROW     = 480;
  localparam int unsigned PYR_COL     = 752;
  localparam int unsigned PYR_IN_W    = 19;
  localparam int unsigned PYR_OUT_W   = 17;
  localparam int unsigned PYR_STALL_W = 20;

endpackage

// File: rtl/pyr_frame_cnt.sv
// Loadable down-counter with zero flag; times both the FLUSH and DRAIN phases.
module pyr_frame_cnt
  import pyr_pkg::*;
#(
  parameter int unsigned W = PYR_IN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // load has priority over decrement; decrement stops at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pyr_frame_ctrl.sv
// Frame sequencer for the 2x2 averaging pyramid stage: gates the stage enable
// from the upstream stream, flushes the last line pair, counts outputs and
// realigns the stage after an abort.
// Optional stall timeout enabled by defining PYR_TIMEOUT_EN.
module pyr_frame_ctrl
  import pyr_pkg::*;
#(
  parameter int unsigned ROW       = PYR_ROW,
  parameter int unsigned COL       = PYR_COL,
  parameter int unsigned FLUSH_CYC = COL,
  parameter int unsigned EXP_OUT   = (ROW / 2) * (COL / 2)
`ifdef PYR_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 1048576
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  output logic                 dp_en,
  input  logic                 dp_out_valid,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 err_count,
  output logic                 err_timeout,
  output logic [PYR_OUT_W-1:0] out_cnt
);

  localparam logic [PYR_IN_W-1:0]  FRAME_PIX = PYR_IN_W'(ROW * COL);
  localparam logic [PYR_IN_W-1:0]  FLUSH_LEN = PYR_IN_W'(FLUSH_CYC);
  localparam logic [PYR_OUT_W-1:0] EXP_CNT   = PYR_OUT_W'(EXP_OUT);
  localparam logic [PYR_OUT_W-1:0] OUT_MAX   = '1;

  pyr_state_e           state, state_nxt;
  logic [PYR_IN_W-1:0]  in_cnt;
  logic [PYR_OUT_W-1:0] out_cnt_nxt;
  logic [PYR_IN_W-1:0]  cnt_load_val;
  logic                 cnt_load, cnt_dec, cnt_zero;
  logic                 xfer, start_ok, out_en, timeout_hit;

  // abort drops ready in its own cycle, so the pixel offered then is refused
  assign xfer     = (state == ST_RUN) && pix_valid && !abort;
  assign start_ok = (state == ST_IDLE) && start && !abort;
  assign out_en   = dp_out_valid &&
                    ((state == ST_RUN) || (state == ST_FLUSH) || (state == ST_DONE));
  assign out_cnt_nxt = (out_en && (out_cnt != OUT_MAX)) ? out_cnt + 1'b1 : out_cnt;
  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_DONE);

  pyr_frame_cnt #(.W(PYR_IN_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // next state, stream handshake, stage enable and phase counter control
  always_comb begin
    state_nxt    = state;
    pix_ready    = 1'b0;
    dp_en        = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        pix_ready = !abort;
        dp_en     = xfer;
        // counter holds cycles-remaining minus one so zero marks the last cycle
        if (abort || timeout_hit) begin
          state_nxt    = ST_DRAIN;
          cnt_load     = 1'b1;
          cnt_load_val = FRAME_PIX - in_cnt + FLUSH_LEN - 1'b1;
        end else if (xfer && (in_cnt == FRAME_PIX - 1'b1)) begin
          state_nxt    = ST_FLUSH;
          cnt_load     = 1'b1;
          cnt_load_val = FLUSH_LEN - 1'b1;
        end
      end
      ST_FLUSH: begin
        dp_en   = 1'b1;
        cnt_dec = 1'b1;
        // an abort mid-flush keeps the remaining flush count so the stage
        // still lands on (0,0); an abort on the final flush cycle skips DONE
        if (cnt_zero)   state_nxt = abort ? ST_IDLE : ST_DONE;
        else if (abort) state_nxt = ST_DRAIN;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        dp_en   = 1'b1;
        cnt_dec = 1'b1;
        if (cnt_zero) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // input/output pixel counters and the output-count error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_cnt    <= '0;
      out_cnt   <= '0;
      err_count <= 1'b0;
    end else if (start_ok) begin
      in_cnt    <= '0;
      out_cnt   <= '0;
      err_count <= 1'b0;
    end else begin
      if (xfer) in_cnt <= in_cnt + 1'b1;
      out_cnt <= out_cnt_nxt;
      // include a pulse landing in the DONE cycle itself
      if ((state == ST_DONE) && (out_cnt_nxt != EXP_CNT)) err_count <= 1'b1;
    end
  end

`ifdef PYR_TIMEOUT_EN
  localparam logic [PYR_STALL_W-1:0] STALL_LAST = PYR_STALL_W'(TIMEOUT - 1);

  logic [PYR_STALL_W-1:0] stall_cnt;

  // fires on the TIMEOUT-th consecutive RUN cycle without a transfer
  assign timeout_hit = (state == ST_RUN) && !abort && !xfer && (stall_cnt == STALL_LAST);

  // stall counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt   <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (start_ok)         err_timeout <= 1'b0;
      else if (timeout_hit) err_timeout <= 1'b1;
      if ((state != ST_RUN) || xfer || timeout_hit) stall_cnt <= '0;
      else                                          stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pyr_frame_ctrl.sv
// Directed bench for pyr_frame_ctrl with reduced frame (4x8, flush 8, 8 outputs)
// and a behavioural 2x2 stage model driving dp_out_valid.
module tb_pyr_frame_ctrl;

  localparam int unsigned TR  = 4;
  localparam int unsigned TC  = 8;
  localparam int unsigned TF  = 8;
  localparam int unsigned PER = TR * TC + TF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, abort = 1'b0, pix_valid = 1'b0;
  logic        pix_ready, dp_en, dp_out_valid, busy, frame_done, err_count, err_timeout;
  logic [16:0] out_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pyr_frame_ctrl #(
    .ROW       (TR),
    .COL       (TC),
    .FLUSH_CYC (TF),
    .EXP_OUT   (8)
`ifdef PYR_TIMEOUT_EN
    , .TIMEOUT (16)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .dp_en        (dp_en),
    .dp_out_valid (dp_out_valid),
    .busy         (busy),
    .frame_done   (frame_done),
    .err_count    (err_count),
    .err_timeout  (err_timeout),
    .out_cnt      (out_cnt)
  );

  // Stage model: position advances on dp_en and wraps after a frame plus flush.
  // Outputs appear one line late, on even rows >= 2 at odd columns.
  int unsigned pos;
  logic        drop = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst)       pos <= 0;
    else if (dp_en) pos <= (pos == PER - 1) ? 0 : pos + 1;
  end

  always_comb begin
    dp_out_valid = dp_en && (pos >= TC) && (((pos / TC) % 2) == 0) &&
                   (((pos % TC) % 2) == 1) && !(drop && (pos == 17));
  end

  typedef struct {
    logic st, ab, pv;
    logic rdy, en, bsy, dn;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // one cycle: drive after the falling edge, observe 1 ns later
  task automatic cycle(input logic st, input logic ab, input logic pv);
    @(negedge clk);
    start = st; abort = ab; pix_valid = pv;
    #1;
  endtask

  task automatic run_to_idle(input string nm, input logic ab, input int limit,
                             output int n, output int en, output int dn, output int dat);
    n = 0; en = 0; dn = 0; dat = 0;
    while (n < limit) begin
      cycle(1'b0, ab, 1'b0);
      n++;
      if (dp_en) en++;
      if (frame_done) begin dn++; dat = n; end
      if (!busy) break;
    end
    chk({nm, "_reach_idle"}, 32'(busy), 0);
  endtask

  task automatic finish_frame(input string nm, input int pixels);
    int n, en, dn, dat;
    for (int k = 0; k < pixels; k++) cycle(1'b0, 1'b0, 1'b1);
    run_to_idle(nm, 1'b0, 80, n, en, dn, dat);
    chk({nm, "_stage_pos"}, pos, 0);
  endtask

  // start in cycle 1, 32 pixels in cycles 2..33, flush 34..41, done in 42
  task automatic nominal_frame(input string nm, input int exp_out, input logic exp_err);
    int n, en, dn, dat;
    cycle(1'b1, 1'b0, 1'b0);
    chk({nm, "_start_cycle_busy"}, 32'(busy), 0);
    for (int k = 0; k < 32; k++) begin
      cycle(1'b0, 1'b0, 1'b1);
      if (k == 0 || k == 31) begin
        chk({nm, "_run_ready"}, 32'(pix_ready), 1);
        chk({nm, "_run_en"}, 32'(dp_en), 1);
      end
    end
    run_to_idle(nm, 1'b0, 80, n, en, dn, dat);
    chk({nm, "_flush_en_cycles"}, en, 8);
    chk({nm, "_done_pulses"}, dn, 1);
    chk({nm, "_done_cycle"}, 33 + dat, 42);
    chk({nm, "_out_cnt"}, 32'(out_cnt), exp_out);
    chk({nm, "_err_count"}, 32'(err_count), 32'(exp_err));
    chk({nm, "_stage_pos"}, pos, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    int n, en, dn, dat, xfers;
    logic pv;

    //               st ab pv  rdy en bsy dn
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};  // reset idle
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};  // start+abort
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};  // still idle
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};  // abort in idle
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};  // start taken
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};  // transfer 1
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};  // gap
    tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};  // start ignored, transfer 2
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};  // gap

    repeat (2) @(negedge clk);
    chk("reset_out_cnt", 32'(out_cnt), 0);
    chk("reset_err_count", 32'(err_count), 0);
    chk("reset_err_timeout", 32'(err_timeout), 0);
    rst = 1'b1;

    // table: idle corner cases and backpressure start of frame
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].st, tbl[i].ab, tbl[i].pv);
      chk($sformatf("vec%0d_ready", i), 32'(pix_ready), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d_en", i), 32'(dp_en), 32'(tbl[i].en));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
      chk($sformatf("vec%0d_done", i), 32'(frame_done), 32'(tbl[i].dn));
    end

    // backpressure: alternate valid until 32 transfers, enable mirrors valid
    xfers = 2;
    for (int i = 0; i < 200 && xfers < 32; i++) begin
      pv = ((i % 2) == 0);
      cycle(1'b0, 1'b0, pv);
      chk("bp_en_mirrors_valid", 32'(dp_en), 32'(pv));
      chk("bp_ready", 32'(pix_ready), 1);
      if (pv) xfers++;
    end
    run_to_idle("bp", 1'b0, 80, n, en, dn, dat);
    chk("bp_flush_en_cycles", en, 8);
    chk("bp_done_pulses", dn, 1);
    chk("bp_done_after_flush", dat, 9);
    chk("bp_out_cnt", 32'(out_cnt), 8);
    chk("bp_stage_pos", pos, 0);

    // nominal frame
    nominal_frame("nom", 8, 1'b0);

    // abort after 10 transfers: 22 + 8 drain cycles, no frame_done
    cycle(1'b1, 1'b0, 1'b0);
    repeat (10) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    chk("ab10_ready_drops", 32'(pix_ready), 0);
    chk("ab10_en_abort_cycle", 32'(dp_en), 0);
    run_to_idle("ab10", 1'b0, 80, n, en, dn, dat);
    chk("ab10_drain_en", en, 30);
    chk("ab10_no_done", dn, 0);
    chk("ab10_out_cnt_held", 32'(out_cnt), 0);
    chk("ab10_stage_pos", pos, 0);
    nominal_frame("ab10_next", 8, 1'b0);

    // abort on the 32nd pixel: refused, drain 1 + 8; abort held through drain
    cycle(1'b1, 1'b0, 1'b0);
    repeat (31) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    chk("ablast_ready_drops", 32'(pix_ready), 0);
    chk("ablast_en", 32'(dp_en), 0);
    run_to_idle("ablast", 1'b1, 80, n, en, dn, dat);
    chk("ablast_drain_en", en, 9);
    chk("ablast_no_done", dn, 0);
    chk("ablast_out_cnt_held", 32'(out_cnt), 4);
    chk("ablast_stage_pos", pos, 0);

    // count error: one output suppressed
    drop = 1'b1;
    nominal_frame("cnterr", 7, 1'b1);
    drop = 1'b0;
    cycle(1'b1, 1'b0, 1'b0);
    chk("cnterr_sticky_before_start", 32'(err_count), 1);
    cycle(1'b0, 1'b0, 1'b1);
    chk("cnterr_cleared_by_start", 32'(err_count), 0);
    chk("out_cnt_cleared_by_start", 32'(out_cnt), 0);
    finish_frame("cnterr_fin", 31);

`ifdef PYR_TIMEOUT_EN
    // 16 stall cycles in RUN trigger the timeout and a full 40-cycle drain
    cycle(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (k == 0 || k == 15) begin
        chk("to_still_run_ready", 32'(pix_ready), 1);
        chk("to_not_yet", 32'(err_timeout), 0);
      end
    end
    run_to_idle("to", 1'b0, 80, n, en, dn, dat);
    chk("to_drain_en", en, 40);
    chk("to_no_done", dn, 0);
    chk("to_err_set", 32'(err_timeout), 1);
    chk("to_stage_pos", pos, 0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    chk("to_cleared_by_start", 32'(err_timeout), 0);
    finish_frame("to_fin", 31);
`else
    // long stall: waits in RUN, no timeout error
    cycle(1'b1, 1'b0, 1'b0);
    repeat (40) cycle(1'b0, 1'b0, 1'b0);
    chk("stall_ready", 32'(pix_ready), 1);
    chk("stall_busy", 32'(busy), 1);
    chk("stall_en", 32'(dp_en), 0);
    chk("stall_no_timeout", 32'(err_timeout), 0);
    finish_frame("stall_fin", 32);
`endif

    // asynchronous reset mid-frame
    cycle(1'b1, 1'b0, 1'b0);
    repeat (21) cycle(1'b0, 1'b0, 1'b1);
    chk("midrst_out_cnt_before", 32'(out_cnt), 2);
    chk("midrst_en_before", 32'(dp_en), 1);
    rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_en", 32'(dp_en), 0);
    chk("midrst_ready", 32'(pix_ready), 0);
    chk("midrst_out_cnt", 32'(out_cnt), 0);
    @(negedge clk);
    pix_valid = 1'b0;
    rst = 1'b1;
    nominal_frame("post_rst", 8, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
